// File: rtl/pkt_types_pkg.sv
// Shared DSI packet definitions: sync byte, data-type codes, FSM states,
// long/short classification and the 24-bit header ECC.
package pkt_types_pkg;

    localparam logic [7:0] SYNC_BYTE     = 8'hB8;
    localparam logic [5:0] DT_EOTP       = 6'h08;
    localparam logic [5:0] DT_DCS_LONG   = 6'h39;
    localparam logic [5:0] DT_DCS_SHORT0 = 6'h05;

    typedef enum logic [3:0] {
        IDLE, DI, WC0, WC1, ECC, PAYLOAD, CS0, CS1, DROP
    } state_t;

    // Long packets have dt[3] set and a non-zero low field.
    function automatic logic is_long(input logic [5:0] dt);
        return dt[3] & (dt[2:0] != 3'd0);
    endfunction

    // Hamming parity over {data1, data0, DI}; bit 0 of DI is header bit 0.
    // Bits [7:6] of the result are always zero.
    function automatic logic [7:0] calc_ecc(input logic [23:0] d);
        logic [7:0] p;
        p    = 8'h00;
        p[0] = ^(d & 24'hF12CB7);
        p[1] = ^(d & 24'hF2555B);
        p[2] = ^(d & 24'h749A6D);
        p[3] = ^(d & 24'hB8E38E);
        p[4] = ^(d & 24'hDF03F0);
        p[5] = ^(d & 24'hEFFC00);
        return p;
    endfunction

endpackage

// File: rtl/pkt_crc16.sv
// Byte-wide CRC-16 (x^16+x^12+x^5+1, LSB-first, init 16'hFFFF, no final XOR).
// clr reloads the init value and takes priority over en.
module pkt_crc16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  din,
    output logic [15:0] crc
);

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
        return r;
    endfunction

    // Running CRC register, one byte folded in per enabled cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      crc <= 16'hFFFF;
        else if (clr) crc <= 16'hFFFF;
        else if (en)  crc <= crc_byte(crc, din);
    end

endmodule

// File: rtl/packetparser.sv
// Receive-side DSI packet parser for a single byte lane.
// Optional payload CRC check is built when PKTPARSE_CRC_CHECK_EN is defined;
// otherwise crc_err is tied low and only the checksum is captured.
module packetparser
    import pkt_types_pkg::*;
(
    input  logic        byte_clk,
    input  logic        reset,
    input  logic        bytepkt_en,
    input  logic [7:0]  bytepkt,
    output logic        hdr_valid,
    output logic [1:0]  vc,
    output logic [5:0]  dt,
    output logic [15:0] wc,
    output logic        ecc_err,
    output logic        payload_en,
    output logic [7:0]  payload,
    output logic        payload_last,
    output logic        chksum_rdy,
    output logic [15:0] chksum,
    output logic        crc_err,
    output logic        eotp_det,
    output logic        sync_err,
    output logic        trunc_err
);

    state_t      state, nxt;
    logic [15:0] cnt;
    logic        ecc_bad;

    // State register.
    always_ff @(posedge byte_clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    // Next-state logic; a dropped enable inside a packet returns to IDLE.
    always_comb begin
        nxt     = state;
        // calc_ecc leaves [7:6] zero, so a full-byte compare also flags
        // non-zero reserved bits.
        ecc_bad = (bytepkt != calc_ecc({wc, vc, dt}));
        case (state)
            IDLE:    if (bytepkt_en) nxt = (bytepkt == SYNC_BYTE) ? DI : DROP;
            DROP:    if (!bytepkt_en) nxt = IDLE;
            DI:      nxt = bytepkt_en ? WC0 : IDLE;
            WC0:     nxt = bytepkt_en ? WC1 : IDLE;
            WC1:     nxt = bytepkt_en ? ECC : IDLE;
            ECC: begin
                if (!bytepkt_en)      nxt = IDLE;
                else if (!is_long(dt)) nxt = DI;
                else if (wc != 16'd0)  nxt = PAYLOAD;
                else                   nxt = CS0;
            end
            PAYLOAD: begin
                if (!bytepkt_en)      nxt = IDLE;
                else if (cnt == 16'd1) nxt = CS0;
            end
            CS0:     nxt = bytepkt_en ? CS1 : IDLE;
            CS1:     nxt = bytepkt_en ? DI : IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Field capture, payload counter and one-cycle status pulses.
    always_ff @(posedge byte_clk or posedge reset) begin
        if (reset) begin
            vc <= '0; dt <= '0; wc <= '0; ecc_err <= 1'b0; cnt <= '0;
            hdr_valid <= 1'b0; payload_en <= 1'b0; payload <= '0;
            payload_last <= 1'b0; chksum_rdy <= 1'b0; chksum <= 16'hFFFF;
            eotp_det <= 1'b0; sync_err <= 1'b0; trunc_err <= 1'b0;
        end else begin
            hdr_valid    <= 1'b0;
            payload_en   <= 1'b0;
            payload_last <= 1'b0;
            chksum_rdy   <= 1'b0;
            eotp_det     <= 1'b0;
            sync_err     <= 1'b0;
            trunc_err    <= 1'b0;
            case (state)
                IDLE: if (bytepkt_en && bytepkt != SYNC_BYTE) sync_err <= 1'b1;
                DI:   if (bytepkt_en) {vc, dt} <= bytepkt;
                WC0: begin
                    if (bytepkt_en) wc[7:0] <= bytepkt;
                    else            trunc_err <= 1'b1;
                end
                WC1: begin
                    if (bytepkt_en) wc[15:8] <= bytepkt;
                    else            trunc_err <= 1'b1;
                end
                ECC: begin
                    if (bytepkt_en) begin
                        hdr_valid <= 1'b1;
                        ecc_err   <= ecc_bad;
                        eotp_det  <= (dt == DT_EOTP) && !ecc_bad;
                        if (is_long(dt)) cnt <= wc;
                    end else begin
                        trunc_err <= 1'b1;
                    end
                end
                PAYLOAD: begin
                    if (bytepkt_en) begin
                        payload_en   <= 1'b1;
                        payload      <= bytepkt;
                        payload_last <= (cnt == 16'd1);
                        cnt          <= cnt - 16'd1;
                    end else begin
                        trunc_err <= 1'b1;
                        cnt       <= '0;
                    end
                end
                CS0: begin
                    if (bytepkt_en) chksum[7:0] <= bytepkt;
                    else            trunc_err <= 1'b1;
                end
                CS1: begin
                    if (bytepkt_en) begin
                        chksum[15:8] <= bytepkt;
                        chksum_rdy   <= 1'b1;
                    end else begin
                        trunc_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PKTPARSE_CRC_CHECK_EN
    logic [15:0] crc_val;

    pkt_crc16 u_crc (
        .clk (byte_clk),
        .rst (reset),
        .clr (state == ECC && bytepkt_en),
        .en  (state == PAYLOAD && bytepkt_en),
        .din (bytepkt),
        .crc (crc_val)
    );

    // With wc==0 the CRC stays at its init value, giving the 16'hFFFF compare.
    always_ff @(posedge byte_clk or posedge reset) begin
        if (reset)                          crc_err <= 1'b0;
        else if (state == CS1 && bytepkt_en) crc_err <= ({bytepkt, chksum[7:0]} != crc_val);
    end
`else
    assign crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_packetparser.sv
// Directed self-checking bench for packetparser. Inputs change on the falling
// edge; registered outputs of a byte are sampled on the following falling edge.
module tb_packetparser;

`ifdef PKTPARSE_CRC_CHECK_EN
    localparam logic CRC_ON = 1'b1;
`else
    localparam logic CRC_ON = 1'b0;
`endif

    logic        byte_clk = 1'b0;
    logic        reset = 1'b1;
    logic        bytepkt_en = 1'b0;
    logic [7:0]  bytepkt = 8'h00;
    logic        hdr_valid, ecc_err, payload_en, payload_last;
    logic        chksum_rdy, crc_err, eotp_det, sync_err, trunc_err;
    logic [1:0]  vc;
    logic [5:0]  dt;
    logic [15:0] wc, chksum;
    logic [7:0]  payload;

    int nchk = 0;
    int nerr = 0;

    // Event counters, written only by the monitor below.
    int n_pay = 0, n_last = 0, n_cs = 0, n_hdr = 0, n_sync = 0, n_trunc = 0;
    logic [23:0] pl_hist = '0;
    int b_pay, b_last, b_cs, b_hdr, b_sync, b_trunc;

    packetparser dut (
        .byte_clk(byte_clk), .reset(reset), .bytepkt_en(bytepkt_en), .bytepkt(bytepkt),
        .hdr_valid(hdr_valid), .vc(vc), .dt(dt), .wc(wc), .ecc_err(ecc_err),
        .payload_en(payload_en), .payload(payload), .payload_last(payload_last),
        .chksum_rdy(chksum_rdy), .chksum(chksum), .crc_err(crc_err),
        .eotp_det(eotp_det), .sync_err(sync_err), .trunc_err(trunc_err)
    );

    always #5 byte_clk = ~byte_clk;

    always @(negedge byte_clk) begin
        if (!reset) begin
            if (payload_en) begin
                n_pay++;
                pl_hist = {pl_hist[15:0], payload};
                if (payload_last) n_last++;
            end
            if (chksum_rdy) n_cs++;
            if (hdr_valid)  n_hdr++;
            if (sync_err)   n_sync++;
            if (trunc_err)  n_trunc++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic e, input logic [7:0] b);
        @(negedge byte_clk);
        bytepkt_en = e;
        bytepkt    = b;
    endtask

    task automatic snap();
        b_pay = n_pay; b_last = n_last; b_cs = n_cs;
        b_hdr = n_hdr; b_sync = n_sync; b_trunc = n_trunc;
    endtask

    // Long DCS packet B8 39 03 00 09 AA BB CC cs0 cs1, then one further drive.
    task automatic long_pkt(input string tag, input logic [7:0] cs0, input logic [7:0] cs1,
                            input logic exp_crc, input logic nxt_en, input logic [7:0] nxt_b);
        drive(1, 8'hB8); drive(1, 8'h39); drive(1, 8'h03); drive(1, 8'h00); drive(1, 8'h09);
        drive(1, 8'hAA);
        chk({tag, " hdr_valid"}, hdr_valid, 1);
        chk({tag, " hdr fields"}, {vc, dt, wc, ecc_err}, {2'd0, 6'h39, 16'h0003, 1'b0});
        drive(1, 8'hBB);
        chk({tag, " pay0"}, {payload_en, payload, payload_last}, {1'b1, 8'hAA, 1'b0});
        drive(1, 8'hCC);
        chk({tag, " pay1"}, {payload_en, payload, payload_last}, {1'b1, 8'hBB, 1'b0});
        drive(1, cs0);
        chk({tag, " pay2 last"}, {payload_en, payload, payload_last}, {1'b1, 8'hCC, 1'b1});
        drive(1, cs1);
        chk({tag, " no pay at cs"}, payload_en, 0);
        drive(nxt_en, nxt_b);
        chk({tag, " chksum_rdy"}, chksum_rdy, 1);
        chk({tag, " chksum"}, chksum, {cs1, cs0});
        chk({tag, " crc_err"}, crc_err, exp_crc);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge byte_clk);
        chk("rst pulses", {hdr_valid, payload_en, payload_last, chksum_rdy, eotp_det, sync_err, trunc_err}, 0);
        chk("rst chksum", chksum, 16'hFFFF);
        chk("rst fields", {vc, dt, wc, ecc_err, crc_err, payload}, 0);
        reset = 1'b0;
        drive(0, 0);
        snap();

        // Short packet
        drive(1, 8'hB8); drive(1, 8'h05); drive(1, 8'h2C); drive(1, 8'h00); drive(1, 8'h25);
        drive(0, 0);
        chk("short hdr_valid", hdr_valid, 1);
        chk("short fields", {vc, dt, wc, ecc_err, eotp_det}, {2'd0, 6'h05, 16'h002C, 1'b0, 1'b0});
        repeat (3) drive(0, 0);
        chk("short no payload", n_pay - b_pay, 0);
        chk("short no trunc", n_trunc - b_trunc, 0);

        // Long packet with correct CRC 16'h9738
        snap();
        long_pkt("long", 8'h38, 8'h97, 1'b0, 0, 0);
        repeat (2) drive(0, 0);
        chk("long payload seq", pl_hist, 24'hAABBCC);
        chk("long counts", {n_pay - b_pay, n_last - b_last, n_cs - b_cs}, {32'd3, 32'd1, 32'd1});

        // Corrupted checksum byte 0
        long_pkt("badcs", 8'h39, 8'h97, CRC_ON, 0, 0);
        repeat (2) drive(0, 0);

        // Long packet, wc=0
        snap();
        drive(1, 8'hB8); drive(1, 8'h39); drive(1, 8'h00); drive(1, 8'h00); drive(1, 8'h0F);
        drive(1, 8'hFF);
        chk("wc0 hdr", {hdr_valid, wc, ecc_err}, {1'b1, 16'h0000, 1'b0});
        drive(1, 8'hFF);
        drive(0, 0);
        chk("wc0 cs", {chksum_rdy, chksum, crc_err}, {1'b1, 16'hFFFF, 1'b0});
        repeat (2) drive(0, 0);
        chk("wc0 no payload", n_pay - b_pay, 0);

        // Long packet chained with EoTp
        snap();
        long_pkt("chain", 8'h38, 8'h97, 1'b0, 1, 8'h08);
        drive(1, 8'h0F); drive(1, 8'h0F); drive(1, 8'h01);
        drive(0, 0);
        chk("eotp hdr", {hdr_valid, dt, wc, ecc_err}, {1'b1, 6'h08, 16'h0F0F, 1'b0});
        chk("eotp_det", eotp_det, 1);
        repeat (3) drive(0, 0);
        chk("eotp no errs", {n_trunc - b_trunc, n_sync - b_sync}, 0);

        // Flipped ECC bit, then EoTp with a bad ECC in the same burst
        drive(1, 8'hB8); drive(1, 8'h05); drive(1, 8'h2C); drive(1, 8'h00); drive(1, 8'h24);
        drive(1, 8'h08);
        chk("eccflip", {hdr_valid, ecc_err}, 2'b11);
        drive(1, 8'h0F); drive(1, 8'h0F); drive(1, 8'h03);
        drive(0, 0);
        chk("eotp badecc", {hdr_valid, dt, ecc_err, eotp_det}, {1'b1, 6'h08, 1'b1, 1'b0});
        repeat (2) drive(0, 0);

        // Bad sync byte; rest of burst ignored
        snap();
        drive(1, 8'h5A); drive(1, 8'hB8);
        chk("sync_err", sync_err, 1);
        drive(1, 8'h39); drive(1, 8'h03); drive(1, 8'h00); drive(1, 8'h09); drive(1, 8'hAA);
        repeat (3) drive(0, 0);
        chk("sync ignored", {n_sync - b_sync, n_hdr - b_hdr, n_pay - b_pay}, {32'd1, 32'd0, 32'd0});
        drive(1, 8'hB8); drive(1, 8'h05); drive(1, 8'h2C); drive(1, 8'h00); drive(1, 8'h25);
        drive(0, 0);
        chk("resync hdr", {hdr_valid, dt, wc, ecc_err}, {1'b1, 6'h05, 16'h002C, 1'b0});
        repeat (2) drive(0, 0);

        // Truncation after 2 of 3 payload bytes
        snap();
        drive(1, 8'hB8); drive(1, 8'h39); drive(1, 8'h03); drive(1, 8'h00); drive(1, 8'h09);
        drive(1, 8'hAA); drive(1, 8'hBB);
        drive(0, 0);
        drive(0, 0);
        chk("trunc_err", {trunc_err, payload_en}, 2'b10);
        repeat (2) drive(0, 0);
        chk("trunc counts", {n_pay - b_pay, n_last - b_last, n_cs - b_cs, n_trunc - b_trunc},
            {32'd2, 32'd0, 32'd0, 32'd1});
        long_pkt("after trunc", 8'h38, 8'h97, 1'b0, 0, 0);
        repeat (2) drive(0, 0);

        // Reset in mid-header aborts silently
        snap();
        drive(1, 8'hB8); drive(1, 8'h39); drive(1, 8'h03);
        @(negedge byte_clk);
        reset = 1'b1; bytepkt_en = 1'b0;
        @(negedge byte_clk);
        chk("midrst quiet", {trunc_err, sync_err, hdr_valid, chksum}, {3'b000, 16'hFFFF});
        reset = 1'b0;
        drive(1, 8'hB8); drive(1, 8'h05); drive(1, 8'h2C); drive(1, 8'h00); drive(1, 8'h25);
        drive(0, 0);
        chk("post rst hdr", {hdr_valid, dt, wc, ecc_err}, {1'b1, 6'h05, 16'h002C, 1'b0});
        repeat (2) drive(0, 0);
        chk("post rst no trunc", n_trunc - b_trunc, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/packetparser.md
# packetparser

Receive-side DSI packet parser for one byte lane. Consumes the byte-serial packet stream (leading sync byte, packet header, payload, checksum, optional EoTp), recovers VC/DT/WC, checks header ECC and optionally payload CRC, and presents payload bytes to the downstream command/pixel logic. It sits between the lane deserializer and the display/command decoders, mirroring the packet builder on the transmit path.

## Interface
- No parameters; the lane is fixed at 1 byte per clock.
- byte_clk  in  1  byte clock.
- reset  in  1  asynchronous, active-high reset.
- bytepkt_en  in  1  byte valid; high for the whole contiguous burst.
- bytepkt  in  8  stream byte.
- hdr_valid  out  1  one-cycle pulse; vc/dt/wc/ecc_err are valid.
- vc  out  2  virtual channel, held until the next header.
- dt  out  6  data type, held until the next header.
- wc  out  16  word count or short-packet data {data1,data0}, held until the next header.
- ecc_err  out  1  header ECC mismatch; qualified by hdr_valid.
- payload_en  out  1  payload byte valid.
- payload  out  8  payload byte.
- payload_last  out  1  marks the final payload byte.
- chksum_rdy  out  1  one-cycle pulse; chksum and crc_err are valid.
- chksum  out  16  received checksum {byte1,byte0}.
- crc_err  out  1  payload CRC mismatch; qualified by chksum_rdy.
- eotp_det  out  1  one-cycle pulse when an EoTp short packet is received with a good ECC.
- sync_err  out  1  one-cycle pulse; the burst's first byte was not 8'hB8.
- trunc_err  out  1  one-cycle pulse; bytepkt_en fell inside a packet.

## Operation
- States: IDLE, DI, WC0, WC1, ECC, PAYLOAD, CS0, CS1, DROP.
- A byte is accepted only when bytepkt_en=1. IDLE performs no action while bytepkt_en=0.
- IDLE, first byte of a burst:
  - 8'hB8 moves the FSM to DI.
  - Any other byte pulses sync_err and moves the FSM to DROP.
- DROP stays in DROP until bytepkt_en=0, then moves to IDLE.
- Header bytes:
  - DI latches {vc,dt}.
  - WC0 latches wc[7:0].
  - WC1 latches wc[15:8].
- ECC state:
  - Computes ECC over {wc,vc,dt} (bits [5:0]) and compares it with the received byte.
  - ecc_err=1 on any mismatch, or if the received byte's bits [7:6] are not 0. There is no correction.
  - hdr_valid pulses.
- Packet type: long if is_long(dt), defined as dt[3] & (dt[2:0]!=0). Otherwise short.
- Short packet:
  - If dt==6'h08 and ecc_err=0, eotp_det pulses.
  - Next state is DI.
- Long packet with wc!=0:
  - A 16-bit down-counter loads wc; next state is PAYLOAD.
  - Each accepted byte drives payload_en.
  - payload_last is asserted when the counter reaches 1; the FSM then moves to CS0.
- Long packet with wc==0: go directly to CS0.
- CS0 latches chksum[7:0]. CS1 latches chksum[15:8], pulses chksum_rdy, and moves the FSM to DI.
- Packets chain without a new sync byte. In DI, if bytepkt_en=0 the FSM returns to IDLE with no error.
- Long packets with ecc_err=1 are still consumed using the received wc. ECC errors do not cause resynchronisation.
- Truncation: if bytepkt_en=0 in WC0, WC1, ECC, PAYLOAD, CS0 or CS1:
  - trunc_err pulses and the FSM moves to IDLE.
  - No payload_last and no chksum_rdy are issued.

## Timing
- All outputs are registered and appear 1 cycle after the corresponding byte is accepted:
  - hdr_valid after the ECC byte.
  - payload_en after each payload byte.
  - chksum_rdy after the CS1 byte.
- Reset values:
  - Every output is 0, except chksum = 16'hFFFF.
  - The FSM is in IDLE and the counter is 0.
- Reset asserted mid-packet aborts the packet immediately. No error pulses are generated.
- sync_err and trunc_err never occur in the same cycle as hdr_valid, payload_en or chksum_rdy.

## Configuration
- PKTPARSE_CRC_CHECK_EN defined:
  - A CRC-16 is computed over the payload: polynomial x^16+x^12+x^5+1, init 16'hFFFF, LSB-first, no final XOR.
  - crc_err = (CRC != chksum), reported at chksum_rdy.
  - When wc==0 the compare value is 16'hFFFF.
- Undefined: crc_err is tied to 0 and no CRC logic is built. The checksum is still captured and reported.

## Structure
- Package pkt_types_pkg holds:
  - SYNC_BYTE = 8'hB8.
  - DT_EOTP = 6'h08.
  - DT_DCS_LONG = 6'h39 and DT_DCS_SHORT0 = 6'h05.
  - Function is_long(dt).
  - Function calc_ecc(24-bit header) returning 8 bits.
  - The state enum.
- The package is shared with the transmit packet builder.
- One sub-module, pkt_crc16: a per-byte CRC update with clear and enable inputs. It is instantiated only under PKTPARSE_CRC_CHECK_EN.

## Test plan
- Short packet: B8, 05, 2C, 00, calc_ecc.
  - Expect hdr_valid, vc=0, dt=05, wc=16'h002C, ecc_err=0.
  - Expect no payload_en.
- Long packet: B8, 39, 03, 00, ECC, AA, BB, CC, CRC(AA BB CC) LSB first.
  - Expect payload AA/BB/CC with payload_last on CC.
  - Expect chksum_rdy, crc_err=0.
  - Corrupting chksum byte 0 gives crc_err=1 (macro on) or crc_err=0 (macro off).
- Long packet, wc=0: B8, 39, 00, 00, ECC, FF, FF.
  - Expect no payload_en, chksum_rdy with chksum=16'hFFFF, crc_err=0.
- Long packet followed by EoTp (08, 0F, 0F, 01) in one burst.
  - Expect chksum_rdy, then hdr_valid with dt=08 and eotp_det pulse.
  - Then bytepkt_en=0 returns the FSM to IDLE with no error.
- ECC byte with one bit flipped: expect ecc_err=1 at hdr_valid.
- First byte 5A: expect sync_err and the remaining burst ignored.
  - Next burst starting B8 parses normally.
- bytepkt_en dropped after 2 of 3 payload bytes: expect trunc_err, no payload_last, no chksum_rdy.
  - Next packet parses correctly.
